// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enc_pkg
//  Brief    : Shared types and constants for the serial frame encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } encState_t;

    // Fixed line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_VAL = 1'b0;
    localparam logic STOP_VAL  = 1'b1;

    // Total clocks occupied by one frame on the line
    function automatic int frame_clocks(input int width, input int parityEn,
                                        input int stopBits, input int manchester);
        return (1 + width + parityEn + stopBits) * ((manchester != 0) ? 2 : 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_phase.sv
`default_nettype none
// ============================================================================
//  Module   : manchester_phase
//  Brief    : Maps an NRZ bit and half-bit phase onto the line level.
//             Manchester: 0 -> 1,0 ; 1 -> 0,1. NRZ: bit passes through.
//  Revision : 1.0 - initial release
// ============================================================================
module manchester_phase #(
    parameter int MANCHESTER = 0
) (
    input  logic nrzBit,
    input  logic phase,
    output logic lineLevel
);

    localparam logic c_encode = (MANCHESTER != 0);

    // First half carries the inverted bit, second half the true bit
    assign lineLevel = nrzBit ^ (c_encode & ~phase);

endmodule
`default_nettype wire

// File: rtl/serial_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_encoder
//  Brief    : Parallel-to-serial framer: start bit, WIDTH data bits, optional
//             parity, 1-2 stop bits, NRZ or Manchester line coding.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_frame_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int MANCHESTER = 0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             inValid,
    output logic             inReady,
    output logic             serialOut,
    output logic             busy,
    output logic             frameDone
);

    localparam int         c_frameClks  = frame_clocks(WIDTH, PARITY_EN, STOP_BITS, MANCHESTER);
    localparam logic [7:0] c_remainInit = 8'(c_frameClks - 1);
    localparam logic [5:0] c_lastData   = 6'(WIDTH - 1);
    localparam logic       c_parityOdd  = (PARITY_ODD != 0);
    localparam logic       c_msbFirst   = (MSB_FIRST != 0);
    localparam logic       c_nrz        = (MANCHESTER == 0);

    encState_t        r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_parity;
    logic             r_bit;
    logic             r_phase;
    logic [5:0]       r_dataCnt;
    logic [7:0]       r_remain;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_bitEnd;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;
    logic             w_encoded;

    assign w_accept  = inValid && r_ready;
    assign w_bitEnd  = c_nrz || r_phase;
    assign w_head    = c_msbFirst ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shifted = c_msbFirst ? (r_shift << 1) : (r_shift >> 1);

    // Frame sequencer: bit/phase stepping plus a frame-length down counter
    // that times the final stop clock for inReady/frameDone
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit     <= LINE_IDLE;
            r_phase   <= 1'b0;
            r_dataCnt <= '0;
            r_remain  <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= parallelIn;
            r_parity  <= (^parallelIn) ^ c_parityOdd;
            r_state   <= START;
            r_bit     <= START_VAL;
            r_phase   <= 1'b0;
            r_dataCnt <= '0;
            r_remain  <= c_remainInit;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else if (r_state == IDLE) begin
            r_done    <= 1'b0;
        end else if (r_remain == 8'd0) begin
            // Final stop clock with nothing queued: return to idle line
            r_state   <= IDLE;
            r_bit     <= LINE_IDLE;
            r_phase   <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_remain  <= r_remain - 8'd1;
            r_ready   <= (r_remain == 8'd1);
            r_done    <= (r_remain == 8'd1);
            if (!w_bitEnd) begin
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                case (r_state)
                    START: begin
                        r_state   <= DATA;
                        r_bit     <= w_head;
                        r_shift   <= w_shifted;
                        r_dataCnt <= '0;
                    end
                    DATA: begin
                        if (r_dataCnt == c_lastData) begin
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_bit   <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_bit   <= STOP_VAL;
                            end
                        end else begin
                            r_bit     <= w_head;
                            r_shift   <= w_shifted;
                            r_dataCnt <= r_dataCnt + 6'd1;
                        end
                    end
                    PARITY: begin
                        r_state <= STOP;
                        r_bit   <= STOP_VAL;
                    end
                    default: begin
                        r_bit   <= STOP_VAL;
                    end
                endcase
            end
        end
    end

    manchester_phase #(
        .MANCHESTER (MANCHESTER)
    ) u_phase (
        .nrzBit    (r_bit),
        .phase     (r_phase),
        .lineLevel (w_encoded)
    );

    // Line is driven only from state flops; idle line is an unencoded 1
    assign serialOut = r_busy ? w_encoded : LINE_IDLE;
    assign inReady   = r_ready;
    assign busy      = r_busy;
    assign frameDone = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_frame_encoder
//  Brief    : Self-checking bench for serial_frame_encoder in four
//             configurations, with a queue of expected line levels.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_encoder;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] inValid;
    logic [3:0] inReady;
    logic [3:0] serialOut;
    logic [3:0] busy;
    logic [3:0] frameDone;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [3:0] din2;
    logic [7:0] din3;

    int checks   = 0;
    int failures = 0;
    logic expQ[$];

    always #5 clk = ~clk;

    // d0: defaults
    serial_frame_encoder u_dut0 (
        .clock(clk), .resetN(resetN), .parallelIn(din0), .inValid(inValid[0]),
        .inReady(inReady[0]), .serialOut(serialOut[0]), .busy(busy[0]), .frameDone(frameDone[0]));

    // d1: LSB first, even parity
    serial_frame_encoder #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clock(clk), .resetN(resetN), .parallelIn(din1), .inValid(inValid[1]),
        .inReady(inReady[1]), .serialOut(serialOut[1]), .busy(busy[1]), .frameDone(frameDone[1]));

    // d2: 4-bit Manchester, two stop bits
    serial_frame_encoder #(.WIDTH(4), .STOP_BITS(2), .MANCHESTER(1)) u_dut2 (
        .clock(clk), .resetN(resetN), .parallelIn(din2), .inValid(inValid[2]),
        .inReady(inReady[2]), .serialOut(serialOut[2]), .busy(busy[2]), .frameDone(frameDone[2]));

    // d3: LSB first, odd parity
    serial_frame_encoder #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u_dut3 (
        .clock(clk), .resetN(resetN), .parallelIn(din3), .inValid(inValid[3]),
        .inReady(inReady[3]), .serialOut(serialOut[3]), .busy(busy[3]), .frameDone(frameDone[3]));

    task automatic set_din(input int d, input logic [31:0] word);
        case (d)
            0: din0 = word[7:0];
            1: din1 = word[7:0];
            2: din2 = word[3:0];
            default: din3 = word[7:0];
        endcase
    endtask

    // Reference model: push the expected line level of every frame clock
    task automatic build_frame(input logic [31:0] word, input int width, input int msbFirst,
                               input int parEn, input int parOdd, input int stopBits,
                               input int manch);
        logic bits[$];
        logic par;
        bits.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < width; i++) begin
            bits.push_back(word[(msbFirst != 0) ? (width - 1 - i) : i]);
            par = par ^ word[i];
        end
        if (parEn != 0) bits.push_back(par ^ (parOdd != 0));
        for (int i = 0; i < stopBits; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            if (manch != 0) begin
                expQ.push_back(~bits[i]);
                expQ.push_back(bits[i]);
            end else begin
                expQ.push_back(bits[i]);
            end
        end
    endtask

    task automatic push_list(input logic [31:0] vals, input int n);
        logic [31:0] v;
        v = vals;
        for (int i = n - 1; i >= 0; i--) expQ.push_back(v[i]);
    endtask

    // Send one word on device d and check every frame clock against expQ
    task automatic run_frame(input int d, input logic [31:0] word, input bit scramble,
                             input string name);
        int   len;
        logic e;
        len = expQ.size();
        @(negedge clk);
        checks++;
        if (inReady[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_pre: got %b expected 1", name, inReady[d]);
        end
        set_din(d, word);
        inValid[d] = 1'b1;
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (serialOut[d] !== e) begin
                failures++;
                $display("FAIL %s_line[%0d]: got %b expected %b", name, i, serialOut[d], e);
            end
            checks++;
            if (frameDone[d] !== (i == len)) begin
                failures++;
                $display("FAIL %s_done[%0d]: got %b expected %b", name, i, frameDone[d], (i == len));
            end
            checks++;
            if (inReady[d] !== (i == len)) begin
                failures++;
                $display("FAIL %s_ready[%0d]: got %b expected %b", name, i, inReady[d], (i == len));
            end
            checks++;
            if (busy[d] !== 1'b1) begin
                failures++;
                $display("FAIL %s_busy[%0d]: got %b expected 1", name, i, busy[d]);
            end
            if (scramble) set_din(d, $urandom);
        end
        @(negedge clk);
        checks++;
        if (serialOut[d] !== 1'b1 || busy[d] !== 1'b0 || frameDone[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: got line=%b busy=%b done=%b expected 1/0/0",
                     name, serialOut[d], busy[d], frameDone[d]);
        end
    endtask

    task automatic test_reset();
        resetN  = 1'b0;
        inValid = 4'b0000;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (serialOut !== 4'hF || inReady !== 4'hF || busy !== 4'h0 || frameDone !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: got line=%b ready=%b busy=%b done=%b expected 1111/1111/0000/0000",
                     serialOut, inReady, busy, frameDone);
        end
        resetN = 1'b1;
    endtask

    task automatic test_nrz_default();
        push_list(32'b0101010001, 10);
        run_frame(0, 32'hA8, 1'b0, "nrz_a8");
        build_frame(32'h00, 8, 1, 0, 0, 1, 0);
        run_frame(0, 32'h00, 1'b0, "nrz_00");
        build_frame(32'hFF, 8, 1, 0, 0, 1, 0);
        run_frame(0, 32'hFF, 1'b0, "nrz_ff");
    endtask

    task automatic test_parity();
        push_list(32'b00001010111, 11);
        run_frame(1, 32'hA8, 1'b0, "par_even_a8");
        build_frame(32'hA8, 8, 0, 1, 1, 1, 0);
        run_frame(3, 32'hA8, 1'b0, "par_odd_a8");
        build_frame(32'h37, 8, 0, 1, 0, 1, 0);
        run_frame(1, 32'h37, 1'b0, "par_even_37");
        build_frame(32'h00, 8, 0, 1, 1, 1, 0);
        run_frame(3, 32'h00, 1'b0, "par_odd_00");
    endtask

    task automatic test_manchester();
        push_list(32'b10011010010101, 14);
        run_frame(2, 32'h9, 1'b0, "man_9");
        build_frame(32'h6, 4, 1, 0, 0, 2, 1);
        run_frame(2, 32'h6, 1'b0, "man_6");
    endtask

    task automatic test_back_to_back();
        int   doneCnt;
        int   firstDone;
        int   secondDone;
        logic e;
        build_frame(32'hA8, 8, 1, 0, 0, 1, 0);
        build_frame(32'h55, 8, 1, 0, 0, 1, 0);
        doneCnt = 0; firstDone = 0; secondDone = 0;
        @(negedge clk);
        din0 = 8'hA8;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        din0 = 8'h55;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (serialOut[0] !== e) begin
                failures++;
                $display("FAIL b2b_line[%0d]: got %b expected %b", i, serialOut[0], e);
            end
            if (frameDone[0] === 1'b1) begin
                doneCnt++;
                if (firstDone == 0) firstDone = i; else secondDone = i;
            end
            if (i == 10) begin
                checks++;
                if (inReady[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_last_stop: got %b expected 1", inReady[0]);
                end
                @(posedge clk);
                #1;
                inValid[0] = 1'b0;
            end
        end
        checks++;
        if (doneCnt != 2 || firstDone != 10 || secondDone != 20) begin
            failures++;
            $display("FAIL b2b_done_pulses: got count=%0d at %0d,%0d expected 2 at 10,20",
                     doneCnt, firstDone, secondDone);
        end
        @(negedge clk);
        checks++;
        if (serialOut[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_after: got line=%b busy=%b expected 1/0", serialOut[0], busy[0]);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        din0 = 8'hFF;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || serialOut[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset: got busy=%b line=%b expected 1/1", busy[0], serialOut[0]);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if (serialOut[0] !== 1'b1 || busy[0] !== 1'b0 || inReady[0] !== 1'b1 || frameDone[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_reset: got line=%b busy=%b ready=%b done=%b expected 1/0/1/0",
                     serialOut[0], busy[0], inReady[0], frameDone[0]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (serialOut[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_held_reset: got line=%b busy=%b expected 1/0", serialOut[0], busy[0]);
        end
        resetN = 1'b1;
        build_frame(32'h5A, 8, 1, 0, 0, 1, 0);
        run_frame(0, 32'h5A, 1'b0, "post_reset");
    endtask

    task automatic test_capture();
        build_frame(32'h3C, 8, 1, 0, 0, 1, 0);
        run_frame(0, 32'h3C, 1'b1, "cap_nrz");
        build_frame(32'hB, 4, 1, 0, 0, 2, 1);
        run_frame(2, 32'hB, 1'b1, "cap_man");
        build_frame(32'hC3, 8, 0, 1, 1, 1, 0);
        run_frame(3, 32'hC3, 1'b1, "cap_par");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (serialOut !== 4'hF || busy !== 4'h0 || inReady !== 4'hF) begin
                failures++;
                $display("FAIL idle[%0d]: got line=%b busy=%b ready=%b expected 1111/0000/1111",
                         i, serialOut, busy, inReady);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nrz_default();
        test_parity();
        test_manchester();
        test_back_to_back();
        test_reset_midframe();
        test_capture();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
